// File: rtl/fetch.sv
// fetch -- instruction fetch stage feeding the execute stage.
//
// Generates sequential word-aligned PCs, keeps exactly one request in flight
// on the instruction memory valid/ready handshake, and buffers returned
// words with their PCs in a small prefetch FIFO. The FIFO head is presented
// to execute as out_valid/out_instr/out_pc. A redirect from execute flushes
// the FIFO, retargets fetch_pc and discards any wrong-path response that is
// still in flight.
//
// Parameters:
//   RESET_PC   PC of the first fetch after reset (4-byte aligned)
//   DEPTH      prefetch FIFO entries (power of two, 2..8)
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   hlt         execute stall: blocks pop and redirect
//   override    redirect request from execute
//   newpc       redirect target, valid with override
//   imem_valid  fetch request valid
//   imem_ready  one-cycle completion pulse, imem_rdata valid
//   imem_addr   fetch word address
//   imem_rdata  returned instruction word
//   out_valid   out_instr/out_pc hold a real instruction
//   out_instr   FIFO head instruction, NOP when empty
//   out_pc      FIFO head PC, previous value when empty
//   fault_align (FETCH_ALIGN_FAULT_EN only) sticky misaligned-redirect flag
//
// Build option: define FETCH_ALIGN_FAULT_EN to trap misaligned redirect
// targets instead of silently clearing newpc[1:0].
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        override,
  input  logic [31:0] newpc,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_ALIGN_FAULT_EN
  ,
  output logic        fault_align
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FULL  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        hold_addr_q, hold_addr_d;
  logic               discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        last_pc_q;

  logic [31:0]        fifo_pc    [DEPTH];
  logic [31:0]        fifo_instr [DEPTH];

  logic               redirect;
  logic               accept;
  logic               push;
  logic               pop;
  logic               bad_align;
  logic               stop_fetch;
  logic [31:0]        target_pc;

  assign target_pc = {newpc[31:2], 2'b00};
  assign redirect  = override & ~hlt;
  assign accept    = (state_q == ISSUE) & imem_ready;
  // A response is only kept when it belongs to the current path.
  assign push      = accept & ~discard_q & ~redirect;
  assign pop       = out_valid & ~hlt & ~redirect;

`ifdef FETCH_ALIGN_FAULT_EN
  logic fault_q;

  assign bad_align   = redirect & (newpc[1:0] != 2'b00);
  assign stop_fetch  = fault_q | bad_align;
  assign fault_align = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (bad_align) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic unused_newpc_lsb;

  assign unused_newpc_lsb = ^newpc[1:0];
  assign bad_align        = 1'b0;
  assign stop_fetch       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    discard_d   = discard_q;
    count_d     = redirect ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    rd_ptr_d    = redirect ? wr_ptr_q : (rd_ptr_q + PTR_W'(pop));
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);

    case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: begin
        if (accept) begin
          discard_d = 1'b0;
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_d == FULL_CNT) ? FULL : ISSUE;
          end else begin
            // Dropped response: fetch_pc already holds the redirect target.
            state_d = stop_fetch ? HALT : ISSUE;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn; keep presenting its address until
          // it completes, then throw its data away.
          discard_d = 1'b1;
          if (!discard_q) begin
            hold_addr_d = fetch_pc_q;
          end
        end
      end
      FULL:    if (count_q < FULL_CNT) state_d = ISSUE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      if (!bad_align) begin
        fetch_pc_d = target_pc;
      end
      if ((state_q == IDLE) || (state_q == FULL)) begin
        state_d = stop_fetch ? HALT : ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      last_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      last_pc_q  <= out_pc;
    end
  end

  // Storage only; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    if (push) begin
      fifo_pc[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_valid = (state_q == ISSUE);
  assign imem_addr  = discard_q ? hold_addr_q : fetch_pc_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = out_valid ? fifo_instr[rd_ptr_q] : NOP;
  // When empty, keep showing whatever PC was presented last cycle.
  assign out_pc     = out_valid ? fifo_pc[rd_ptr_q] : last_pc_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch -- directed bench for the fetch stage (DEPTH=2, RESET_PC=0).
module tb_fetch;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        hlt;
  logic        override;
  logic [31:0] newpc;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_ALIGN_FAULT_EN
  logic        fault_align;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .hlt        (hlt),
    .override   (override),
    .newpc      (newpc),
    .imem_valid (imem_valid),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
`ifdef FETCH_ALIGN_FAULT_EN
    ,
    .fault_align(fault_align)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and advance to the first ISSUE cycle (fetch of RESET_PC).
  task automatic reset_seq();
    rst        = 1'b1;
    hlt        = 1'b0;
    override   = 1'b0;
    newpc      = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // ---- reset values
    rst = 1'b1; hlt = 1'b0; override = 1'b0; newpc = 32'h0;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;   // ready during reset is ignored
    tick();
    tick();
    chk("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", out_pc, 32'h0);
`ifdef FETCH_ALIGN_FAULT_EN
    chk("rst_fault", {31'b0, fault_align}, 32'd0);
`endif
    imem_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("first_valid", {31'b0, imem_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // ---- streaming, zero-wait memory
    imem_ready = 1'b1;
    imem_rdata = 32'h0 ^ K;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_out_pc", out_pc, 32'(4 * k));
      chk("stream_out_instr", out_instr, 32'(4 * k) ^ K);
      chk("stream_addr", imem_addr, 32'(4 * (k + 1)));
      imem_rdata = 32'(4 * (k + 1)) ^ K;
    end

    // ---- hold hlt for 10 cycles: two pushes then FULL; override ignored
    reset_seq();
    hlt = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'h0 ^ K;
    tick();
    imem_rdata = 32'h4 ^ K;
    tick();
    imem_ready = 1'b0;
    chk("hlt_full_valid", {31'b0, imem_valid}, 32'd0);
    override = 1'b1; newpc = 32'h300;
    tick();
    tick();
    override = 1'b0;
    repeat (6) tick();
    chk("hlt_still_full", {31'b0, imem_valid}, 32'd0);
    chk("hlt_head_pc", out_pc, 32'h0);
    chk("hlt_head_instr", out_instr, 32'h0 ^ K);
    hlt = 1'b0;
    tick();
    chk("hlt_pop2_pc", out_pc, 32'h4);
    chk("hlt_pop2_instr", out_instr, 32'h4 ^ K);
    tick();
    chk("hlt_empty", {31'b0, out_valid}, 32'd0);
    chk("hlt_empty_pc", out_pc, 32'h4);
    chk("hlt_empty_instr", out_instr, NOP);
    chk("hlt_resume_valid", {31'b0, imem_valid}, 32'd1);
    chk("hlt_resume_addr", imem_addr, 32'h8);

    // ---- imem_ready delayed 3 cycles on the request to 0x4
    reset_seq();
    imem_ready = 1'b1; imem_rdata = 32'h0 ^ K;
    tick();
    imem_ready = 1'b0;
    chk("wait_addr0", imem_addr, 32'h4);
    for (int w = 1; w < 4; w++) begin
      tick();
      chk("wait_addr", imem_addr, 32'h4);
      chk("wait_valid", {31'b0, imem_valid}, 32'd1);
      chk("wait_out_valid", {31'b0, out_valid}, 32'd0);
    end
    imem_ready = 1'b1; imem_rdata = 32'h4 ^ K;
    tick();
    chk("wait_done_pc", out_pc, 32'h4);
    chk("wait_done_instr", out_instr, 32'h4 ^ K);
    chk("wait_next_addr", imem_addr, 32'h8);

    // ---- redirect while request to 0x8 outstanding
    imem_ready = 1'b0;
    override = 1'b1; newpc = 32'h100;
    tick();
    override = 1'b0;
    chk("rd_flush", {31'b0, out_valid}, 32'd0);
    chk("rd_hold_addr", imem_addr, 32'h8);
    tick();
    chk("rd_hold_addr2", imem_addr, 32'h8);
    imem_ready = 1'b1; imem_rdata = 32'h8 ^ K;
    tick();
    chk("rd_stale_dropped", {31'b0, out_valid}, 32'd0);
    chk("rd_new_addr", imem_addr, 32'h100);
    imem_rdata = 32'h100 ^ K;
    tick();
    chk("rd_first_pc", out_pc, 32'h100);
    chk("rd_first_instr", out_instr, 32'h100 ^ K);

    // ---- redirect coinciding with imem_ready
    imem_rdata = 32'h104 ^ K;
    override = 1'b1; newpc = 32'h200;
    tick();
    override = 1'b0;
    chk("rr_flush", {31'b0, out_valid}, 32'd0);
    chk("rr_keep_pc", out_pc, 32'h100);
    chk("rr_addr", imem_addr, 32'h200);
    imem_rdata = 32'h200 ^ K;
    tick();
    chk("rr_first_pc", out_pc, 32'h200);

    // ---- PC wraps modulo 2^32
    imem_rdata = 32'h204 ^ K;
    override = 1'b1; newpc = 32'hFFFF_FFFC;
    tick();
    override = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'hFFFF_FFFC ^ K;
    tick();
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", out_instr, 32'h5A5A_5A59);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // ---- misaligned redirect target
    imem_rdata = 32'h0 ^ K;
    override = 1'b1; newpc = 32'h102;
    tick();
    override = 1'b0;
    imem_ready = 1'b0;
    chk("mis_flush", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_ALIGN_FAULT_EN
    chk("mis_fault", {31'b0, fault_align}, 32'd1);
    chk("mis_valid", {31'b0, imem_valid}, 32'd0);
    tick();
    tick();
    chk("mis_still_halted", {31'b0, imem_valid}, 32'd0);
    chk("mis_sticky", {31'b0, fault_align}, 32'd1);
    reset_seq();
    chk("mis_rst_clear", {31'b0, fault_align}, 32'd0);
    chk("mis_rst_valid", {31'b0, imem_valid}, 32'd1);
`else
    chk("mis_valid", {31'b0, imem_valid}, 32'd1);
    chk("mis_addr", imem_addr, 32'h100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
